// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
// No logic here; imported by the controller.
// No flow control involved.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/f_a.sv
// Single-bit full adder cell.
// Purely combinational, zero latency.
// No flow control.
module f_a (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c_in,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_c_in;
    assign o_carry = (i_a & i_b) | (i_c_in & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder_ctrl_dp.sv
// Serial adder datapath: operand shift registers, carry register, result shifter.
// One bit per step; result complete on the step flagged as last.
// No backpressure: i_load and i_step are obeyed unconditionally.
module serial_adder_ctrl_dp #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_last,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             fa_sum;
    logic             fa_carry;

    f_a u_f_a (
        .i_a     (a_sh[0]),
        .i_b     (b_sh[0]),
        .i_c_in  (carry_r),
        .o_sum   (fa_sum),
        .o_carry (fa_carry)
    );

    // Sum bits enter at the MSB and drift down, so after WIDTH steps bit i sits at sum_r[i].
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_sh        <= '0;
            b_sh        <= '0;
            carry_r     <= 1'b0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
        end else if (i_load) begin
            a_sh        <= i_a;
            b_sh        <= i_b;
            carry_r     <= i_c_in;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
        end else if (i_step) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            carry_r <= fa_carry;
            sum_r   <= {fa_sum, sum_r[WIDTH-1:1]};
            if (i_last) begin
                carry_out_r <= fa_carry;
            end
        end
    end

    assign o_sum   = sum_r;
    assign o_carry = carry_out_r;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts a start, adds LSB-first over WIDTH cycles, pulses o_done.
// Latency WIDTH edges from the accepting edge to o_done; back-to-back starts accepted on the o_done cycle.
// Starts arriving while busy are dropped, not queued.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             step;
    logic             last;

    assign accept = i_start && ((state == ST_IDLE) || (state == ST_DONE));
    assign step   = (state == ST_RUN);
    assign last   = step && (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_start) state_nxt = ST_RUN;
            ST_RUN:  if (last)    state_nxt = ST_DONE;
            ST_DONE: state_nxt = i_start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state)
            ST_RUN:  o_busy = 1'b1;
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    // Counter parks on its final value so it never wraps within an operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_cnt <= '0;
        end else if (accept) begin
            bit_cnt <= '0;
        end else if (step && !last) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    serial_adder_ctrl_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (accept),
        .i_step  (step),
        .i_last  (last),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_c_in  (i_c_in),
        .o_sum   (o_sum),
        .o_carry (o_carry)
    );

endmodule
